// File: rtl/or_unit_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : or_unit_arbiter_if
// Description : Bundle of request, operand, acknowledge and result signals
//               between the client blocks and the shared OR unit arbiter.
//   in_req    [NUM_REQ]         per-requester request, level-sensitive
//   in_a      [NUM_REQ*DATA_W]  operand A, requester i at [i*DATA_W +: DATA_W]
//   in_b      [NUM_REQ*DATA_W]  operand B, same packing as in_a
//   in_ack    [1]               consumer accepts the held result
//   out_grant [NUM_REQ]         one-hot grant, zero when idle
//   out_c     [DATA_W]          registered a|b of the granted requester
//   out_valid [1]               out_c is valid
//   out_busy  [1]               arbiter is not idle
//   Modports: master = client/consumer side, slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface or_unit_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) ();

  logic [NUM_REQ-1:0]        in_req;
  logic [NUM_REQ*DATA_W-1:0] in_a;
  logic [NUM_REQ*DATA_W-1:0] in_b;
  logic                      in_ack;
  logic [NUM_REQ-1:0]        out_grant;
  logic [DATA_W-1:0]         out_c;
  logic                      out_valid;
  logic                      out_busy;

  modport master (
    output in_req, in_a, in_b, in_ack,
    input  out_grant, out_c, out_valid, out_busy
  );

  modport slave (
    input  in_req, in_a, in_b, in_ack,
    output out_grant, out_c, out_valid, out_busy
  );

endinterface
`default_nettype wire

// File: rtl/or_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : or_unit_arbiter
// Description : Shares one registered DATA_W-bit OR unit (c = a | b) between
//               NUM_REQ requesters. A 3-state FSM (IDLE -> COMPUTE -> HOLD)
//               grants one requester, captures its operands, and holds the
//               result until the consumer acknowledges it.
// Ports       : clk   - rising-edge clock
//               rst_n - synchronous active-low reset
//               bus   - or_unit_arbiter_if.slave (requests, operands,
//                       ack, grant, result, valid, busy)
// Build option: OR_ARB_FIXED_PRIO_EN - when defined, the rotating pointer is
//               removed and IDLE always grants the lowest-index request
//               (fixed priority, starvation possible). Undefined = round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module or_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  or_unit_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  grant_nxt;
  logic [DATA_W-1:0]   c;
  logic [DATA_W-1:0]   c_nxt;
  logic                valid;
  logic                valid_nxt;

  logic [NUM_REQ-1:0]  pick;       // one-hot winner among current requests
  logic [DATA_W-1:0]   sel_or;     // a|b of the currently granted requester
  logic                req_still;  // granted requester still requesting

`ifndef OR_ARB_FIXED_PRIO_EN
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]    last;       // index of the most recently served requester
  logic [IDX_W-1:0]    last_nxt;
  logic [IDX_W-1:0]    grant_idx;

  // Walk offsets from farthest (last itself) to nearest (last+1); the nearest
  // set request is written last and therefore wins.
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.in_req[(int'(last) + k) % NUM_REQ]) begin
        pick = '0;
        pick[(int'(last) + k) % NUM_REQ] = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
  end
`else
  // Descending scan so the lowest set index is written last and wins.
  always_comb begin
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.in_req[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end
`endif

  // Grant is one-hot in COMPUTE, so OR-accumulating the masked slices is a mux.
  always_comb begin
    sel_or = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_or = sel_or | bus.in_a[i*DATA_W +: DATA_W] | bus.in_b[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_still = |(grant & bus.in_req);

  // Next-state and next-output decode.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    c_nxt     = c;
    valid_nxt = valid;
`ifndef OR_ARB_FIXED_PRIO_EN
    last_nxt  = last;
`endif
    case (state)
      S_IDLE: begin
        if (|bus.in_req) begin
          grant_nxt = pick;
          state_nxt = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (req_still) begin
          c_nxt     = sel_or;
          valid_nxt = 1'b1;
          state_nxt = S_HOLD;
        end else begin
          // Requester withdrew before capture: abort without touching the
          // round-robin pointer.
          grant_nxt = '0;
          state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (bus.in_ack) begin
          valid_nxt = 1'b0;
          grant_nxt = '0;
`ifndef OR_ARB_FIXED_PRIO_EN
          last_nxt  = grant_idx;
`endif
          state_nxt = S_IDLE;
        end
      end
      default: begin
        grant_nxt = '0;
        valid_nxt = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      grant <= '0;
      c     <= '0;
      valid <= 1'b0;
`ifndef OR_ARB_FIXED_PRIO_EN
      last  <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      c     <= c_nxt;
      valid <= valid_nxt;
`ifndef OR_ARB_FIXED_PRIO_EN
      last  <= last_nxt;
`endif
    end
  end

  assign bus.out_grant = grant;
  assign bus.out_c     = c;
  assign bus.out_valid = valid;
  assign bus.out_busy  = (state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/or_unit_arbiter.md
Name: or_unit_arbiter

Overview:
- Shares one registered DATA_W-bit OR unit between NUM_REQ requesters. The unit computes out_c = a | b.
- Round-robin arbitration plus a 3-state FSM sequence grant, operand capture, result hold and acknowledge.
- Sits between multiple client blocks and the bitwise OR datapath.
- Only one OR operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand and result width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_req  input  NUM_REQ  per-requester request, level-sensitive.
- in_a  input  NUM_REQ*DATA_W  operand A, flattened; requester i uses bits [i*DATA_W +: DATA_W].
- in_b  input  NUM_REQ*DATA_W  operand B, same packing as in_a.
- in_ack  input  1  consumer accepts the result.
- out_grant  output  NUM_REQ  one-hot grant; all zero when idle.
- out_c  output  DATA_W  registered result a|b of the granted requester.
- out_valid  output  1  out_c is valid.
- out_busy  output  1  FSM is not IDLE.

Behaviour:
- Reset: on a clk edge with rst_n=0:
  - state=IDLE, out_grant=0, out_c=0, out_valid=0, out_busy=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority after reset.
  - Reset asserted mid-transaction aborts it immediately at that edge; no valid is emitted.
- State IDLE:
  - If any in_req bit is set, grant the first set bit searching from last+1 upward with wrap-around.
  - Register that one-hot value into out_grant and go to COMPUTE.
  - If no in_req bit is set, stay in IDLE.
- State COMPUTE (one cycle):
  - If in_req[g] is still 1: out_c <= in_a[g] | in_b[g], out_valid <= 1, go to HOLD.
  - If in_req[g] has dropped: abort. Clear out_grant, go to IDLE, leave last unchanged.
- State HOLD:
  - out_c, out_valid and out_grant stay stable until in_ack=1.
  - On in_ack=1: clear out_valid and out_grant, set last=g, go to IDLE.
  - A new grant can be issued no earlier than the cycle after IDLE is re-entered.
- Latency: request sampled at edge N → out_grant at N+1 → out_valid at N+2. Minimum transaction is 3 cycles with in_ack tied high.
- Requester rules:
  - Operands of the granted requester are sampled only at the COMPUTE edge.
  - Changing operands in HOLD does not affect out_c.
  - Dropping in_req in HOLD has no effect; the result is still held until in_ack.
- in_ack is ignored when out_valid=0.
- out_busy = (state != IDLE), decoded combinationally from the state register.
- Simultaneous requests are resolved strictly by the round-robin order. No requester waits more than NUM_REQ-1 transactions.
- out_grant is always one-hot or zero. At most one bit is ever set.

Optional Feature:
- Macro: OR_ARB_FIXED_PRIO_EN.
- When defined: the rotating pointer is removed, and IDLE always grants the lowest-index set in_req bit. Fixed priority; starvation is allowed.
- When undefined: round-robin as specified above.
- All other FSM timing is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_req=4'b1111 → out_grant=0, out_valid=0, out_busy=0, out_c=8'h00 throughout.
- Single request: in_req=4'b0100, a2=8'hA0, b2=8'h05, in_ack=1 → out_grant=4'b0100 at N+1; out_c=8'hA5 with out_valid=1 at N+2; out_grant=0 at N+3.
- Round-robin: in_req=4'b1111 held, in_ack=1 → grants in order 0001, 0010, 0100, 1000, 0001. With OR_ARB_FIXED_PRIO_EN defined → 0001 every transaction.
- Hold/backpressure: requester 1 with a=8'h0F, b=8'hF0, in_ack=0 for 5 cycles, operands changed to 8'h00 during HOLD → out_c stays 8'hFF and out_valid=1 until in_ack pulses; then out_valid=0 the next cycle.
- Abort: grant requester 3, drop in_req[3] in the COMPUTE cycle → out_valid never asserts, FSM returns to IDLE, next grant with in_req=4'b1001 goes to requester 0 (last unchanged).
- Mid-transaction reset: assert rst_n=0 while in HOLD with out_valid=1 → at the next edge all outputs are 0; after release, in_req=4'b0011 grants requester 0 first.
